// File: rtl/mac_result_writer.sv
// mac_result_writer: shadows the lane accumulators on the ALU write strobe,
// then streams them one word per granted cycle into the result SRAM.
module mac_result_writer #(
    parameter int unsigned LANES = 7,
    parameter int unsigned DW    = 20,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic [LANES*DW-1:0]   mu_flat,
    input  logic                  mem_gnt,
    input  logic                  ptr_clr,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   shadow_q [LANES];
    logic [DW-1:0]   shadow_d [LANES];
    logic [AW-1:0]   ptr_inc;
    logic            load;

    // Address after the current word, wrapping at the last SRAM word
    always_comb begin
        ptr_inc = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end

    // Next-state: capture, drain sequencing, overrun and pointer clear
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        load     = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            shadow_d[i] = shadow_q[i];
        end

        if (ptr_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cap_en) begin
                    load    = 1'b1;
                    lane_d  = '0;
                    state_d = ST_WRITE;
                end else if (ptr_clr) begin
                    wr_ptr_d = '0;
                end
            end
            ST_WRITE: begin
                if (mem_gnt) begin
                    wr_ptr_d = ptr_inc;
                    if (lane_q == LW'(LANES - 1)) begin
                        done_d = 1'b1;
                        // A capture on the final grant chains straight into the next row
                        if (cap_en) begin
                            load   = 1'b1;
                            lane_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                        if (cap_en) begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (cap_en) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                shadow_d[i] = mu_flat[(LANES - 1 - i) * DW +: DW];
            end
        end
    end

    // State, pointer, status and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Select the shadow word for the current lane
    always_comb begin
        mem_wdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                mem_wdata = shadow_q[i];
            end
        end
    end

    assign mem_we   = (state_q == ST_WRITE);
    assign busy     = (state_q == ST_WRITE);
    assign mem_addr = wr_ptr_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// Directed bench for mac_result_writer with hand-computed expectations.
module tb_mac_result_writer;

    localparam int unsigned LANES = 7;
    localparam int unsigned DW    = 20;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic                clk;
    logic                rst;
    logic                cap_en;
    logic [LANES*DW-1:0] mu_flat;
    logic                mem_gnt;
    logic                ptr_clr;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                busy;
    logic                done;
    logic                ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor counters (cumulative; tests compare deltas)
    int n_we   = 0;
    int n_acc  = 0;
    int n_done = 0;

    logic [DW-1:0] exp_row [LANES];

    bit stall_gnt  [11] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    int stall_lane [11] = '{0, 1, 2, 2, 2, 3, 4, 5, 5, 5, 6};

    mac_result_writer #(
        .LANES(LANES), .DW(DW), .AW(AW), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .mu_flat   (mu_flat),
        .mem_gnt   (mem_gnt),
        .ptr_clr   (ptr_clr),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write cycles, accepted writes and done pulses
    always @(posedge clk) begin
        if (mem_we) n_we = n_we + 1;
        if (mem_we && mem_gnt) n_acc = n_acc + 1;
        if (done) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] f;
        for (int i = 0; i < int'(LANES); i++) f[i*DW +: DW] = v;
        return f;
    endfunction

    // Lane 0 occupies the MSBs
    function automatic logic [LANES*DW-1:0] pack_exp();
        logic [LANES*DW-1:0] f;
        for (int i = 0; i < int'(LANES); i++) f[(int'(LANES) - 1 - i)*DW +: DW] = exp_row[i];
        return f;
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < int'(LANES); i++) exp_row[i] = DW'(i + 1);
    endtask

    task automatic set_const(input logic [DW-1:0] v);
        for (int i = 0; i < int'(LANES); i++) exp_row[i] = v;
    endtask

    task automatic capture(input logic [LANES*DW-1:0] flat);
        cap_en  = 1'b1;
        mu_flat = flat;
        tick();
        cap_en  = 1'b0;
    endtask

    // Checks seven fully granted writes; optionally raises cap_en at lane cap_at
    task automatic write_row_check(input string tag, input int base, input int cap_at,
                                   input logic [LANES*DW-1:0] cap_flat);
        mem_gnt = 1'b1;
        for (int k = 0; k < int'(LANES); k++) begin
            check({tag, "_we"},   32'(mem_we), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_addr"}, 32'(mem_addr), 32'((base + k) % int'(DEPTH)));
            check({tag, "_data"}, 32'(mem_wdata), 32'(exp_row[k]));
            if (k == cap_at) begin
                cap_en  = 1'b1;
                mu_flat = cap_flat;
            end
            tick();
            cap_en = 1'b0;
        end
    endtask

    task automatic pulse_ptr_clr();
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
    endtask

    initial begin
        int we0, acc0, done0;
        rst = 1'b1; cap_en = 1'b0; mu_flat = '0; mem_gnt = 1'b1; ptr_clr = 1'b0;
        tick();
        tick();
        check("rst_we",   32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf",  32'(ovf), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Single row, lanes 1..7, addresses 0..6
        set_ramp();
        done0 = n_done;
        capture(pack_exp());
        write_row_check("row1", 0, -1, '0);
        check("row1_done",  32'(done), 32'd1);
        check("row1_busy",  32'(busy), 32'd0);
        check("row1_we",    32'(mem_we), 32'd0);
        tick();
        check("row1_done_clr", 32'(done), 32'd0);
        check("row1_ptr",      32'(mem_addr), 32'd7);
        check("row1_ndone",    32'(n_done - done0), 32'd1);

        // Stall on lanes 2 and 5 for two cycles each
        pulse_ptr_clr();
        check("clr_ptr", 32'(mem_addr), 32'd0);
        we0 = n_we; acc0 = n_acc;
        capture(pack_exp());
        for (int j = 0; j < 11; j++) begin
            mem_gnt = stall_gnt[j];
            check("stall_we",   32'(mem_we), 32'd1);
            check("stall_addr", 32'(mem_addr), 32'(stall_lane[j]));
            check("stall_data", 32'(mem_wdata), 32'(stall_lane[j] + 1));
            check("stall_done", 32'(done), 32'd0);
            tick();
        end
        mem_gnt = 1'b1;
        check("stall_end_done", 32'(done), 32'd1);
        check("stall_n_we",     32'(n_we - we0), 32'd11);
        check("stall_n_acc",    32'(n_acc - acc0), 32'd7);
        tick();

        // Back-to-back rows chained on the final grant
        pulse_ptr_clr();
        we0 = n_we; acc0 = n_acc; done0 = n_done;
        set_const(20'hFFFFF);
        capture(pack_exp());
        write_row_check("b2b_a", 0, 6, fill(20'h12345));
        check("b2b_mid_done", 32'(done), 32'd1);
        check("b2b_mid_busy", 32'(busy), 32'd1);
        set_const(20'h12345);
        write_row_check("b2b_b", 7, -1, '0);
        check("b2b_done",   32'(done), 32'd1);
        check("b2b_busy",   32'(busy), 32'd0);
        check("b2b_ovf",    32'(ovf), 32'd0);
        check("b2b_n_we",   32'(n_we - we0), 32'd14);
        check("b2b_n_acc",  32'(n_acc - acc0), 32'd14);
        tick();
        check("b2b_n_done", 32'(n_done - done0), 32'd2);

        // Overrun: second capture at lane 3 is dropped
        pulse_ptr_clr();
        we0 = n_we;
        set_ramp();
        capture(pack_exp());
        write_row_check("ovr", 0, 3, fill(20'hABCDE));
        check("ovr_done", 32'(done), 32'd1);
        check("ovr_ovf",  32'(ovf), 32'd1);
        tick();
        check("ovr_busy", 32'(busy), 32'd0);
        check("ovr_n_we", 32'(n_we - we0), 32'd7);
        check("ovr_ovf_sticky", 32'(ovf), 32'd1);
        pulse_ptr_clr();
        check("ovr_ovf_clr", 32'(ovf), 32'd0);
        check("ovr_ptr_clr", 32'(mem_addr), 32'd0);

        // Wrap: advance to 252 with 36 full rows, then straddle the end
        for (int r = 0; r < 36; r++) begin
            capture(fill(20'h00000));
            for (int c = 0; c < 20 && !done; c++) tick();
            check("adv_done", 32'(done), 32'd1);
        end
        tick();
        check("wrap_start", 32'(mem_addr), 32'd252);
        set_ramp();
        capture(pack_exp());
        write_row_check("wrap", 252, -1, '0);
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_ptr",  32'(mem_addr), 32'd3);
        tick();

        // Reset mid-row at lane 4
        set_const(20'h5A5A5);
        capture(pack_exp());
        for (int k = 0; k < 4; k++) begin
            check("mrst_addr", 32'(mem_addr), 32'(3 + k));
            tick();
        end
        check("mrst_lane4", 32'(mem_wdata), 32'h5A5A5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_we",   32'(mem_we), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'd0);
        check("mrst_data", 32'(mem_wdata), 32'd0);
        tick();
        check("mrst_nodone", 32'(done), 32'd0);
        set_ramp();
        capture(pack_exp());
        write_row_check("post_rst", 0, -1, '0);
        check("post_rst_done", 32'(done), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_result_writer.md
# mac_result_writer

Write-back end of the matrix MAC datapath. Captures the seven 20-bit lane accumulators in the cycle the ALU raises its write strobe, then drains them one word per accepted cycle into the result SRAM at an auto-incrementing address. Shadow registers free the ALU to start the next row immediately. Provides a memory grant stall, busy/done status and a sticky overrun flag for the controller.

## Interface
Parameters:
- LANES, 7, number of lane results captured per strobe
- DW, 20, width of each lane result and memory word
- AW, 8, result SRAM address width
- DEPTH, 256, number of SRAM words; the address wraps at DEPTH-1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cap_en  in  1  capture strobe, the ALU web; sampled every cycle
- mu_flat  in  LANES*DW  lane results; lane 0 (MU1) in the MSBs [139:120], lane 6 in [19:0]
- mem_gnt  in  1  SRAM accepts the current write this cycle
- ptr_clr  in  1  clears ovf; resets wr_ptr to 0 when the block is idle
- mem_we  out  1  write request
- mem_addr  out  AW  write address, equal to wr_ptr
- mem_wdata  out  DW  write data, shadow[lane]
- busy  out  1  high in WRITE state
- done  out  1  one-cycle pulse after the last lane is accepted
- ovf  out  1  sticky: a capture was dropped

## Operation
- Registers: shadow[0..LANES-1] (DW each), lane index (3 bits), wr_ptr (AW), state, done, ovf.
- IDLE
  - mem_we=0.
  - If cap_en=1: load all shadows from mu_flat, set lane=0, go to WRITE.
- WRITE
  - mem_we=1, mem_addr=wr_ptr, mem_wdata=shadow[lane].
  - mem_gnt=0: hold all outputs stable; no state change.
  - mem_gnt=1 and lane<LANES-1: increment lane and wr_ptr.
  - mem_gnt=1 and lane=LANES-1: increment wr_ptr, set done=1 for the next cycle, go to IDLE.
- Final-grant overlap: if cap_en=1 in the same cycle as the final grant, the capture is accepted. Shadows reload, lane=0 and the state stays WRITE, so writes run back-to-back. The done pulse still fires and ovf is not set.
- Any other cap_en=1 while in WRITE: the capture is dropped, shadows are unchanged and ovf is set to 1.
- wr_ptr arithmetic: wr_ptr+1, with DEPTH-1 wrapping to 0. A write sequence may straddle the wrap.
- ptr_clr
  - Clears ovf in any state.
  - Sets wr_ptr=0 only in IDLE and when no capture occurs that cycle.
  - In WRITE it has no effect on the pointer.
- Data is passed unmodified: no truncation, saturation or sign handling. Results are unsigned DW-bit values.
- Reset: all outputs, shadows, lane, wr_ptr and ovf become 0 and the state becomes IDLE. Reset has priority over every other input. Reset in the middle of a sequence abandons the remaining lanes, and no done pulse is produced.

## Timing
- Capture in cycle N: the first mem_we=1 appears in N+1 with shadow[0] on mem_wdata.
- With mem_gnt held at 1:
  - lanes 0..6 are written in N+1..N+7 at addresses P..P+6;
  - busy=1 in N+1..N+7;
  - done=1 in N+8 only, with busy=0.
- Each mem_gnt=0 cycle extends the sequence by exactly one cycle.
- Back-to-back captures (next cap_en in N+7): the next row is written in N+8..N+14 at P+7..P+13, and done is still high in N+8.
- Minimum capture-to-capture spacing without overrun is LANES cycles with mem_gnt held at 1.
- Outputs are driven by registers or state decode only; there is no combinational path from cap_en or mu_flat to any output.

## Test plan
- Single row: reset, then cap_en for 1 cycle with lanes 1..7 = 0x00001..0x00007 and mem_gnt=1. Required: writes to addr 0..6 with data 1..7 in cycles 1..7, then done in cycle 8 and busy=0.
- Stall: same row with mem_gnt low on lanes 2 and 5 for 2 cycles each. Required: addr/data held during each stall, 11 write cycles in total, exactly 7 accepted, done one cycle after the last grant.
- Back-to-back: two rows (0xFFFFF for all lanes, then 0x12345 for all lanes) with the second cap_en on the final-grant cycle. Required: 14 consecutive writes at addr 0..13, ovf=0, two done pulses.
- Overrun: a second cap_en at lane 3 of the first row. Required: ovf=1, first-row data unaffected, no extra writes. A following ptr_clr clears ovf.
- Wrap: with DEPTH=256, advance wr_ptr to 252, then capture. Required: addresses 252, 253, 254, 255, 0, 1, 2.
- Reset mid-row: assert rst at lane 4. Required: the next cycle shows mem_we=0, busy=0, done=0 and wr_ptr=0; a subsequent capture writes starting at addr 0.
